paint_arbiter: RTL and testbench

Arbiter and sequencer for the shared rectangle-fill engine (`paint_chess`). It accepts rectangle-fill requests from up to `NUM_REQ` painters, such as the board background, chess pieces, pointer and status banner. Requests are granted round-robin. For each grant it drives the engine's start/rectangle/colour inputs, waits for completion, then acknowledges the requester. It replaces the per-painter busy-wait counters, so no two painters ever drive the engine at once.

---
 rtl/paint_arbiter.sv | 262 ++++++++++++++++++++++++++
 tb/tb_paint_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/paint_arbiter.sv
// paint_arbiter -- round-robin arbiter and sequencer for the shared rectangle-fill
// engine. Each grant latches one requester's rectangle and colour, pulses the
// engine start level for HOLD cycles, then waits out a per-grant cycle budget
// before acknowledging the requester.
//
// Optional feature macro: PAINT_ARB_ENGINE_BUSY_EN
//   defined   -> adds the eng_busy input; WAIT also ends on the first low eng_busy
//                after it has been seen high, and the cycle budget becomes a timeout.
//   undefined -> completion is purely counter based.

`ifndef SCR_WIDTH_BITS
`define SCR_WIDTH_BITS 10
`endif
`ifndef SCR_HEIGHT_BITS
`define SCR_HEIGHT_BITS 9
`endif
`ifndef COLOR_SIZE
`define COLOR_SIZE 3
`endif

module paint_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int X_BITS      = `SCR_WIDTH_BITS,
    parameter int Y_BITS      = `SCR_HEIGHT_BITS,
    parameter int C_BITS      = `COLOR_SIZE,
    parameter int HOLD        = 4,
    parameter int CYC_PER_PIX = 6,
    parameter int SLACK       = 10
) (
    input  logic                      Clck,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*X_BITS-1:0] req_x_start,
    input  logic [NUM_REQ*X_BITS-1:0] req_x_end,
    input  logic [NUM_REQ*Y_BITS-1:0] req_y_start,
    input  logic [NUM_REQ*Y_BITS-1:0] req_y_end,
    input  logic [NUM_REQ*C_BITS-1:0] req_color,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      busy,
    output logic [2:0]                grant_id,
    output logic [X_BITS-1:0]         eng_x_start,
    output logic [X_BITS-1:0]         eng_x_end,
    output logic [Y_BITS-1:0]         eng_y_start,
    output logic [Y_BITS-1:0]         eng_y_end,
    output logic [C_BITS-1:0]         eng_color,
    output logic                      eng_working
`ifdef PAINT_ARB_ENGINE_BUSY_EN
    ,
    input  logic                      eng_busy
`endif
);

    localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         rr_ptr_q, rr_ptr_d;
    logic [2:0]         grant_q, grant_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [X_BITS-1:0]  xs_q, xs_d, xe_q, xe_d;
    logic [Y_BITS-1:0]  ys_q, ys_d, ye_q, ye_d;
    logic [C_BITS-1:0]  col_q, col_d;
    logic               working_q;
`ifdef PAINT_ARB_ENGINE_BUSY_EN
    logic               seen_q, seen_d;
`endif

    // Requester fields unpacked into 8-entry tables so a 3-bit index selects exactly.
    logic [7:0]         req_pad;
    logic [X_BITS-1:0]  xs_arr [8];
    logic [X_BITS-1:0]  xe_arr [8];
    logic [Y_BITS-1:0]  ys_arr [8];
    logic [Y_BITS-1:0]  ye_arr [8];
    logic [C_BITS-1:0]  col_arr [8];

    logic               win_found;
    logic [2:0]         win_idx;
    logic [3:0]         cand;
    logic [X_BITS-1:0]  sel_xs, sel_xe;
    logic [Y_BITS-1:0]  sel_ys, sel_ye;
    logic               sel_empty;
    logic [31:0]        x_span, y_span, area, cnt_load;
    logic               wait_done;

    assign req_pad = 8'(req);

    // Unpack the flattened requester buses into per-requester tables.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        for (int i = 0; i < 8; i++) begin
            xs_arr[i]  = '0;
            xe_arr[i]  = '0;
            ys_arr[i]  = '0;
            ye_arr[i]  = '0;
            col_arr[i] = '0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            xs_arr[i]  = req_x_start[i*X_BITS +: X_BITS];
            xe_arr[i]  = req_x_end[i*X_BITS +: X_BITS];
            ys_arr[i]  = req_y_start[i*Y_BITS +: Y_BITS];
            ye_arr[i]  = req_y_end[i*Y_BITS +: Y_BITS];
            col_arr[i] = req_color[i*C_BITS +: C_BITS];
        end
    end

    // Round-robin scan: first asserted request at or after rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + 4'(k);
            if (cand >= 4'(NUM_REQ)) begin
                cand = cand - 4'(NUM_REQ);
            end
            if (!win_found && req_pad[cand[2:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[2:0];
            end
        end
    end

    // Winner's rectangle, emptiness test and wait budget in 32-bit unsigned arithmetic.
    always_comb begin
        sel_xs    = xs_arr[win_idx];
        sel_xe    = xe_arr[win_idx];
        sel_ys    = ys_arr[win_idx];
        sel_ye    = ye_arr[win_idx];
        sel_empty = (sel_xe <= sel_xs) || (sel_ye <= sel_ys);
        x_span    = 32'(sel_xe) - 32'(sel_xs);
        y_span    = 32'(sel_ye) - 32'(sel_ys);
        area      = x_span * y_span;
        cnt_load  = area * 32'(CYC_PER_PIX) + 32'(SLACK);
    end

    // Next-state logic for the grant sequencer.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        xs_d      = xs_q;
        xe_d      = xe_q;
        ys_d      = ys_q;
        ye_d      = ye_q;
        col_d     = col_q;
        wait_done = (cnt_q == '0);
`ifdef PAINT_ARB_ENGINE_BUSY_EN
        seen_d    = seen_q;
        if (seen_q && !eng_busy) begin
            wait_done = 1'b1;
        end
`endif
        unique case (state_q)
            IDLE: begin
`ifdef PAINT_ARB_ENGINE_BUSY_EN
                seen_d = 1'b0;
`endif
                if (win_found) begin
                    grant_d = win_idx;
                    xs_d    = sel_xs;
                    xe_d    = sel_xe;
                    ys_d    = sel_ys;
                    ye_d    = sel_ye;
                    col_d   = col_arr[win_idx];
                    cnt_d   = cnt_load;
                    hold_d  = '0;
                    state_d = sel_empty ? DONE : LOAD;
                end
            end
            LOAD: begin
`ifdef PAINT_ARB_ENGINE_BUSY_EN
                if (eng_busy) seen_d = 1'b1;
`endif
                if (hold_q == HOLD_W'(HOLD - 1)) begin
                    state_d = WAIT;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            WAIT: begin
`ifdef PAINT_ARB_ENGINE_BUSY_EN
                if (eng_busy) seen_d = 1'b1;
`endif
                if (wait_done) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            DONE: begin
                rr_ptr_d = (grant_q == 3'(NUM_REQ - 1)) ? 3'd0 : grant_q + 3'd1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge Clck) begin
        // NOTE: non-blocking assignments keep every register updating from pre-edge values.
        if (!Reset) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            cnt_q     <= '0;
            hold_q    <= '0;
            xs_q      <= '0;
            xe_q      <= '0;
            ys_q      <= '0;
            ye_q      <= '0;
            col_q     <= '0;
            working_q <= 1'b0;
`ifdef PAINT_ARB_ENGINE_BUSY_EN
            seen_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            xs_q      <= xs_d;
            xe_q      <= xe_d;
            ys_q      <= ys_d;
            ye_q      <= ye_d;
            col_q     <= col_d;
            working_q <= (state_d == LOAD);
`ifdef PAINT_ARB_ENGINE_BUSY_EN
            seen_q    <= seen_d;
`endif
        end
    end

    // One-hot completion pulse for the granted requester while in DONE.
    always_comb begin
        ack = '0;
        if (state_q == DONE) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                ack[i] = (grant_q == 3'(i));
            end
        end
    end

    assign busy        = (state_q != IDLE);
    assign grant_id    = grant_q;
    assign eng_x_start = xs_q;
    assign eng_x_end   = xe_q;
    assign eng_y_start = ys_q;
    assign eng_y_end   = ye_q;
    assign eng_color   = col_q;
    assign eng_working = working_q;

endmodule

// File: tb/tb_paint_arbiter.sv
// Testbench for paint_arbiter: directed scenarios plus random requesters, checked by
// a transaction-level reference model feeding a scoreboard queue and an ack monitor.
module tb_paint_arbiter;

    localparam int NUM_REQ     = 3;
    localparam int X_BITS      = 10;
    localparam int Y_BITS      = 9;
    localparam int C_BITS      = 3;
    localparam int HOLD        = 4;
    localparam int CYC_PER_PIX = 6;
    localparam int SLACK       = 10;

    logic                      Clck;
    logic                      Reset;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*X_BITS-1:0] req_x_start, req_x_end;
    logic [NUM_REQ*Y_BITS-1:0] req_y_start, req_y_end;
    logic [NUM_REQ*C_BITS-1:0] req_color;
    logic [NUM_REQ-1:0]        ack;
    logic                      busy;
    logic [2:0]                grant_id;
    logic [X_BITS-1:0]         eng_x_start, eng_x_end;
    logic [Y_BITS-1:0]         eng_y_start, eng_y_end;
    logic [C_BITS-1:0]         eng_color;
    logic                      eng_working;
`ifdef PAINT_ARB_ENGINE_BUSY_EN
    logic                      eng_busy;
`endif

    paint_arbiter #(
        .NUM_REQ(NUM_REQ), .X_BITS(X_BITS), .Y_BITS(Y_BITS), .C_BITS(C_BITS),
        .HOLD(HOLD), .CYC_PER_PIX(CYC_PER_PIX), .SLACK(SLACK)
    ) dut (
        .Clck(Clck), .Reset(Reset), .req(req),
        .req_x_start(req_x_start), .req_x_end(req_x_end),
        .req_y_start(req_y_start), .req_y_end(req_y_end),
        .req_color(req_color), .ack(ack), .busy(busy), .grant_id(grant_id),
        .eng_x_start(eng_x_start), .eng_x_end(eng_x_end),
        .eng_y_start(eng_y_start), .eng_y_end(eng_y_end),
        .eng_color(eng_color), .eng_working(eng_working)
`ifdef PAINT_ARB_ENGINE_BUSY_EN
        , .eng_busy(eng_busy)
`endif
    );

    typedef struct {
        int                id;
        int                ack_cyc;
        int                epoch;
        logic [X_BITS-1:0] xs, xe;
        logic [Y_BITS-1:0] ys, ye;
        logic [C_BITS-1:0] col;
    } exp_t;

    exp_t               exp_q[$];
    int                 n_checks = 0;
    int                 n_fail   = 0;
    int                 cyc      = 0;
    int                 rst_epoch = 0;
    logic [NUM_REQ-1:0] ack_last = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
        end
    endtask

    initial begin
        Clck = 1'b0;
        forever #5 Clck = ~Clck;
    end

    // Cycle counter; every edge with Reset low starts a new reset epoch.
    initial forever begin
        @(posedge Clck);
        cyc++;
        if (Reset === 1'b0) rst_epoch++;
    end

    // Reference model: decides grants from the request levels, spec latencies and rr order.
    int   m_epoch = 0;
    int   g_cyc = -1, a_cyc = -1, next_free = 0, rr = 0, win, lat, sx, sy;
    bit   g_empty = 1'b0;
    logic [31:0] cnt32;
    exp_t e_new;
    initial forever begin
        @(negedge Clck);
        if (m_epoch != rst_epoch) begin
            m_epoch = rst_epoch;
            g_cyc = -1; a_cyc = -1; rr = 0; next_free = cyc;
        end
        check("busy", 64'(busy), 64'(g_cyc >= 0 && cyc > g_cyc && cyc <= a_cyc));
        check("eng_working", 64'(eng_working),
              64'(g_cyc >= 0 && !g_empty && cyc > g_cyc && cyc <= g_cyc + HOLD));
        if (Reset === 1'b1 && cyc >= next_free && req != '0) begin
            win = -1;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (win < 0 && req[(rr + k) % NUM_REQ]) win = (rr + k) % NUM_REQ;
            end
            e_new.id    = win;
            e_new.epoch = m_epoch;
            e_new.xs    = req_x_start[win*X_BITS +: X_BITS];
            e_new.xe    = req_x_end[win*X_BITS +: X_BITS];
            e_new.ys    = req_y_start[win*Y_BITS +: Y_BITS];
            e_new.ye    = req_y_end[win*Y_BITS +: Y_BITS];
            e_new.col   = req_color[win*C_BITS +: C_BITS];
            sx = int'(e_new.xe) - int'(e_new.xs);
            sy = int'(e_new.ye) - int'(e_new.ys);
            g_empty = (sx <= 0 || sy <= 0);
            if (g_empty) begin
                lat = 1;
            end else begin
                cnt32 = 32'(longint'(sx) * longint'(sy) * CYC_PER_PIX + SLACK);
                lat = HOLD + int'(cnt32) + 2;
            end
            e_new.ack_cyc = cyc + lat;
            exp_q.push_back(e_new);
            g_cyc = cyc;
            a_cyc = cyc + lat;
            next_free = a_cyc + 1;
            rr = (win + 1) % NUM_REQ;
        end
    end

    // Monitor: pops the scoreboard when an ack is due and checks the DUT's presentation.
    exp_t               e_mon;
    logic [NUM_REQ-1:0] oh;
    initial forever begin
        @(negedge Clck);
        ack_last = ack;
        while (exp_q.size() > 0 && exp_q[0].epoch != rst_epoch) void'(exp_q.pop_front());
        if (exp_q.size() > 0 && exp_q[0].ack_cyc == cyc) begin
            e_mon = exp_q.pop_front();
            oh = '0;
            oh[e_mon.id] = 1'b1;
            check("ack", 64'(ack), 64'(oh));
            check("grant_id", 64'(grant_id), 64'(e_mon.id));
            check("eng_x_start", 64'(eng_x_start), 64'(e_mon.xs));
            check("eng_x_end", 64'(eng_x_end), 64'(e_mon.xe));
            check("eng_y_start", 64'(eng_y_start), 64'(e_mon.ys));
            check("eng_y_end", 64'(eng_y_end), 64'(e_mon.ye));
            check("eng_color", 64'(eng_color), 64'(e_mon.col));
        end else begin
            check("ack_quiet", 64'(ack), 64'd0);
        end
    end

    task automatic step();
        @(posedge Clck);
        #2;
    endtask

    task automatic set_req(input int i, input int xs, input int xe, input int ys,
                           input int ye, input int col);
        req_x_start[i*X_BITS +: X_BITS] = X_BITS'(xs);
        req_x_end[i*X_BITS +: X_BITS]   = X_BITS'(xe);
        req_y_start[i*Y_BITS +: Y_BITS] = Y_BITS'(ys);
        req_y_end[i*Y_BITS +: Y_BITS]   = Y_BITS'(ye);
        req_color[i*C_BITS +: C_BITS]   = C_BITS'(col);
        req[i] = 1'b1;
    endtask

    task automatic rand_req(input int i);
        int xs, xe, ys, ye;
        xs = $urandom_range(0, 40);
        xe = xs + $urandom_range(0, 5);
        if ($urandom_range(0, 7) == 0) xe = $urandom_range(0, xs);
        ys = $urandom_range(0, 40);
        ye = ys + $urandom_range(0, 5);
        if ($urandom_range(0, 7) == 0) ye = $urandom_range(0, ys);
        set_req(i, xs, xe, ys, ye, $urandom_range(0, 7));
    endtask

    task automatic wait_ack(output int at, output logic [NUM_REQ-1:0] val);
        at  = -1;
        val = '0;
        for (int n = 0; n < 400; n++) begin
            @(negedge Clck);
            if (ack !== '0) begin
                at  = cyc;
                val = ack;
                break;
            end
        end
        if (at < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL ack_timeout at cycle %0d: got no ack, want one within 400 cycles", cyc);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        step();
        Reset = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge Clck);
        check({tag, "_ack"}, 64'(ack), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_grant_id"}, 64'(grant_id), 64'd0);
        check({tag, "_eng_x_start"}, 64'(eng_x_start), 64'd0);
        check({tag, "_eng_x_end"}, 64'(eng_x_end), 64'd0);
        check({tag, "_eng_y_start"}, 64'(eng_y_start), 64'd0);
        check({tag, "_eng_y_end"}, 64'(eng_y_end), 64'd0);
        check({tag, "_eng_color"}, 64'(eng_color), 64'd0);
        check({tag, "_eng_working"}, 64'(eng_working), 64'd0);
    endtask

    int                 t0, at, seen2;
    logic [NUM_REQ-1:0] av;
    logic [NUM_REQ-1:0] order [4];

    initial begin
        Reset = 1'b0;
        req = '0;
        req_x_start = '0; req_x_end = '0;
        req_y_start = '0; req_y_end = '0;
        req_color = '0;
`ifdef PAINT_ARB_ENGINE_BUSY_EN
        eng_busy = 1'b0;
`endif
        repeat (3) step();
        Reset = 1'b1;
        check_reset_outputs("reset");

        // Single request: area 8, cnt 58, ack 64 cycles after the sampling cycle.
        step();
        set_req(0, 10, 14, 5, 7, 6);
        t0 = cyc;
        wait_ack(at, av);
        check("single_latency", 64'(at - t0), 64'd64);
        check("single_ack", 64'(av), 64'b001);
        check("single_color", 64'(eng_color), 64'b110);
        step();
        req[0] = 1'b0;

        // Simultaneous requests from reset: grants 0,1,2 then 0 again.
        step();
        do_reset();
        set_req(0, 0, 2, 0, 2, 1);
        set_req(1, 5, 7, 5, 7, 2);
        set_req(2, 9, 11, 9, 11, 5);
        for (int n = 0; n < 4; n++) begin
            wait_ack(at, av);
            order[n] = av;
        end
        step();
        req = '0;
        check("rr_order0", 64'(order[0]), 64'b001);
        check("rr_order1", 64'(order[1]), 64'b010);
        check("rr_order2", 64'(order[2]), 64'b100);
        check("rr_order3", 64'(order[3]), 64'b001);

        // Empty rectangle: ack one cycle after sampling, engine never started.
        step();
        step();
        set_req(1, 20, 20, 0, 5, 4);
        t0 = cyc;
        wait_ack(at, av);
        check("empty_latency", 64'(at - t0), 64'd1);
        check("empty_ack", 64'(av), 64'b010);
        step();
        req[1] = 1'b0;

        // Withdrawal: requester 2 asks while requester 0 is busy, then gives up.
        step();
        set_req(0, 0, 3, 0, 3, 2);
        repeat (10) step();
        set_req(2, 1, 2, 1, 2, 7);
        repeat (5) step();
        req[2] = 1'b0;
        wait_ack(at, av);
        check("withdraw_ack", 64'(av), 64'b001);
        step();
        req[0] = 1'b0;
        seen2 = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge Clck);
            if (ack[2]) seen2++;
        end
        check("withdraw_no_ack2", 64'(seen2), 64'd0);
        check("withdraw_idle", 64'(busy), 64'd0);

        // Reset in the middle of WAIT, then a fresh request is served normally.
        step();
        set_req(0, 0, 3, 0, 3, 3);
        t0 = cyc;
        while (cyc < t0 + 20) step();
        Reset = 1'b0;
        req = '0;
        step();
        Reset = 1'b1;
        check_reset_outputs("midreset");
        step();
        set_req(1, 4, 6, 4, 5, 5);
        t0 = cyc;
        wait_ack(at, av);
        check("post_reset_latency", 64'(at - t0), 64'd28);
        check("post_reset_ack", 64'(av), 64'b010);
        step();
        req[1] = 1'b0;

        // Random requesters: raise, occasionally withdraw, drop after ack.
        for (int n = 0; n < 3000; n++) begin
            step();
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req[i] && ack_last[i]) req[i] = 1'b0;
                else if (req[i] && $urandom_range(0, 63) == 0) req[i] = 1'b0;
                else if (!req[i] && $urandom_range(0, 3) == 0) rand_req(i);
            end
        end
        req = '0;

        for (int n = 0; n < 1000; n++) begin
            @(negedge Clck);
            if (exp_q.size() == 0) break;
        end
        check("drain", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, want completion before 500000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
